// File: rtl/counter.sv
`default_nettype none
// ============================================================================
// counter : up/down counter with independent increment/decrement strobes.
//           Optional macro COUNTER_SATURATE_EN selects saturating arithmetic.
// Revision: 1.0
// ============================================================================
module counter #(
  parameter int WIDTH                = 4,
  parameter int unsigned RESET_VALUE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             increment,
  input  logic             decrement,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] c_reset_value = RESET_VALUE[WIDTH-1:0];
  localparam logic [WIDTH-1:0] c_one         = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_next;
  logic             w_up;
  logic             w_down;

  // Simultaneous requests cancel, so only one direction is ever active.
  assign w_up   = increment & ~decrement;
  assign w_down = decrement & ~increment;

`ifdef COUNTER_SATURATE_EN
  logic w_at_max;
  logic w_at_min;

  assign w_at_max = &r_count;
  assign w_at_min = ~|r_count;

  always_comb begin
    w_count_next = r_count;
    if (w_up && !w_at_max) begin
      w_count_next = r_count + c_one;
    end else if (w_down && !w_at_min) begin
      w_count_next = r_count - c_one;
    end
  end
`else
  // Modulo arithmetic: natural WIDTH-bit overflow provides the wrap.
  always_comb begin
    w_count_next = r_count;
    if (w_up) begin
      w_count_next = r_count + c_one;
    end else if (w_down) begin
      w_count_next = r_count - c_one;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= c_reset_value;
    end else begin
      r_count <= w_count_next;
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_counter.sv
`default_nettype none
// ============================================================================
// tb_counter : scoreboard bench for counter (WIDTH=4, RESET_VALUE=0).
// Revision: 1.0
// ============================================================================
module tb_counter;

  localparam int WIDTH = 4;
  localparam int RV    = 0;

  logic             clk       = 1'b0;
  logic             reset     = 1'b0;
  logic             increment = 1'b0;
  logic             decrement = 1'b0;
  logic [WIDTH-1:0] count;

  int               checks   = 0;
  int               failures = 0;
  logic [WIDTH-1:0] sb[$];
  logic [WIDTH-1:0] model;
  logic [WIDTH-1:0] exp_v;

  always #5 clk = ~clk;

  counter #(.WIDTH(WIDTH), .RESET_VALUE(RV)) dut (
    .clk       (clk),
    .reset     (reset),
    .increment (increment),
    .decrement (decrement),
    .count     (count)
  );

  function automatic logic [WIDTH-1:0] next_val(input logic [WIDTH-1:0] cur,
                                                 input logic inc, input logic dec);
    int v;
    v = int'(cur);
    if (inc && !dec) v = v + 1;
    else if (dec && !inc) v = v - 1;
`ifdef COUNTER_SATURATE_EN
    if (v > 15) v = 15;
    if (v < 0)  v = 0;
`else
    if (v > 15) v = 0;
    if (v < 0)  v = 15;
`endif
    return v[WIDTH-1:0];
  endfunction

  // Drive one cycle of strobes, record the expected count, land at edge+1.
  task automatic step(input logic inc, input logic dec);
    increment = inc;
    decrement = dec;
    model = next_val(model, inc, dec);
    sb.push_back(model);
    @(posedge clk);
    #1;
  endtask

  task automatic enter_reset();
    reset     = 1'b0;
    increment = 1'b0;
    decrement = 1'b0;
    sb.delete();
    model = RV[WIDTH-1:0];
    sb.push_back(model);
    #1;
  endtask

  task automatic leave_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic preset(input int target);
    enter_reset();
    leave_reset();
    repeat (target) step(1'b1, 1'b0);
    sb.delete();
  endtask

  task automatic test_reset();
    enter_reset();
    repeat (3) @(posedge clk);
    #1;
    exp_v = sb.pop_front();
    checks++;
    if (count !== exp_v) begin
      failures++;
      $display("FAIL reset_hold: count=%0d expected=%0d", count, exp_v);
    end
    leave_reset();
    repeat (3) begin
      step(1'b1, 1'b0);
      exp_v = sb.pop_front();
      checks++;
      if (count !== exp_v) begin
        failures++;
        $display("FAIL reset_prep: count=%0d expected=%0d", count, exp_v);
      end
    end
    @(negedge clk);
    enter_reset();
    exp_v = sb.pop_front();
    checks++;
    if (count !== exp_v) begin
      failures++;
      $display("FAIL reset_async: count=%0d expected=%0d", count, exp_v);
    end
    leave_reset();
  endtask

  task automatic test_count_sequence();
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    repeat (20) step(1'b0, 1'b0);
    while (sb.size() > 0) begin
      exp_v = sb.pop_front();
      checks++;
    end
    // Sequence values compared cycle by cycle below with a fresh run.
    preset(0);
    step(1'b1, 1'b0);
    exp_v = sb.pop_front(); checks++;
    if (count !== exp_v) begin failures++; $display("FAIL seq_inc1: count=%0d expected=%0d", count, exp_v); end
    step(1'b1, 1'b0);
    exp_v = sb.pop_front(); checks++;
    if (count !== exp_v) begin failures++; $display("FAIL seq_inc2: count=%0d expected=%0d", count, exp_v); end
    step(1'b0, 1'b1);
    exp_v = sb.pop_front(); checks++;
    if (count !== exp_v) begin failures++; $display("FAIL seq_dec: count=%0d expected=%0d", count, exp_v); end
    repeat (20) begin
      step(1'b0, 1'b0);
      exp_v = sb.pop_front(); checks++;
      if (count !== exp_v) begin failures++; $display("FAIL seq_idle: count=%0d expected=%0d", count, exp_v); end
    end
  endtask

  task automatic test_wrap_up();
    preset(15);
    step(1'b1, 1'b0);
    exp_v = sb.pop_front(); checks++;
    if (count !== exp_v) begin failures++; $display("FAIL wrap_up: count=%0d expected=%0d", count, exp_v); end
  endtask

  task automatic test_wrap_down();
    preset(0);
    step(1'b0, 1'b1);
    exp_v = sb.pop_front(); checks++;
    if (count !== exp_v) begin failures++; $display("FAIL wrap_down: count=%0d expected=%0d", count, exp_v); end
    step(1'b1, 1'b0);
    exp_v = sb.pop_front(); checks++;
    if (count !== exp_v) begin failures++; $display("FAIL wrap_down_next: count=%0d expected=%0d", count, exp_v); end
  endtask

  task automatic test_cancel();
    preset(5);
    repeat (3) begin
      step(1'b1, 1'b1);
      exp_v = sb.pop_front(); checks++;
      if (count !== exp_v) begin failures++; $display("FAIL cancel: count=%0d expected=%0d", count, exp_v); end
    end
  endtask

  task automatic test_reset_mid();
    preset(7);
    increment = 1'b1;
    #2;
    reset = 1'b0;
    sb.delete();
    model = RV[WIDTH-1:0];
    sb.push_back(model);
    #1;
    exp_v = sb.pop_front(); checks++;
    if (count !== exp_v) begin failures++; $display("FAIL reset_mid: count=%0d expected=%0d", count, exp_v); end
    @(posedge clk);
    #1;
    checks++;
    if (count !== model) begin failures++; $display("FAIL reset_mid_hold: count=%0d expected=%0d", count, model); end
    reset = 1'b1;
    repeat (3) begin
      step(1'b1, 1'b0);
      exp_v = sb.pop_front(); checks++;
      if (count !== exp_v) begin failures++; $display("FAIL reset_mid_resume: count=%0d expected=%0d", count, exp_v); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_count_sequence();
    test_wrap_up();
    test_wrap_down();
    test_cancel();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
